dest_reader: RTL

//  Drains the D0/D1 destination FIFOs at the egress end of the QoS

---
 rtl/dest_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dest_reader.sv
// dest_reader: egress drain for the D0/D1 destination FIFOs.
// Pops both FIFOs round-robin while the consumer is ready, merges the two
// streams into one output stream, keeps saturating per-destination word
// counters and reports idle status.
// Optional feature macro: DEST_CHECK_EN (destination-bit mismatch checker).
module dest_reader #(
  parameter int BW       = 6,
  parameter int CNT_W    = 8,
  parameter int DEST_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic             sink_ready,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic [BW-1:0]    data_out,
  output logic             valid_out,
  output logic             dest_out,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             idle_out,
  output logic             error_out
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rr_ptr;     // 0: D0 wins the next tie, 1: D1 wins
  logic            rd_q;       // a pop was issued last cycle
  logic            src_q;      // source FIFO of that pop
  logic [BW-1:0]   data_hold;  // last presented word
  logic            both_empty;
  logic            pop;

  assign both_empty = D0_empty && D1_empty;
  assign pop        = D0_rd || D1_rd;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: run while the consumer is ready and there is work.
  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!init && sink_ready && !both_empty) state_nxt = READ;
      READ: if (init || !sink_ready || both_empty)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop selection: one pop per cycle, round-robin on a tie, never an empty FIFO.
  always_comb begin
    D0_rd = 1'b0;
    D1_rd = 1'b0;
    if (state == READ && sink_ready && !init) begin
      if (!D0_empty && !D1_empty) begin
        if (rr_ptr) D1_rd = 1'b1;
        else        D0_rd = 1'b0 | 1'b1;
      end else if (!D0_empty) begin
        D0_rd = 1'b1;
      end else if (!D1_empty) begin
        D1_rd = 1'b1;
      end
    end
  end

  // Pop tracking and arbitration pointer. After any pop the pointer names
  // the other FIFO: that is the toggle on a tie and the hand-over when only
  // one FIFO had data.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_q   <= 1'b0;
      src_q  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      rd_q <= pop;
      if (pop) src_q <= D1_rd;
      if (init)     rr_ptr <= 1'b0;
      else if (pop) rr_ptr <= D0_rd;
    end
  end

  // NOTE: the FIFO read data is only valid in the cycle after the pop, so
  // the word is steered through with a registered select and a registered
  // copy holds it once valid_out drops.
  assign valid_out = rd_q;
  assign dest_out  = src_q;
  assign data_out  = rd_q ? (src_q ? D1_data_out : D0_data_out) : data_hold;

  // Hold the last presented word for the cycles without a valid word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  data_hold <= '0;
    else if (rd_q) data_hold <= data_out;
  end

  // Saturating per-destination counters; a word shown during init is not counted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (init) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (rd_q) begin
      if (!src_q && cnt_D0 != '1) cnt_D0 <= cnt_D0 + CNT_W'(1);
      if ( src_q && cnt_D1 != '1) cnt_D1 <= cnt_D1 + CNT_W'(1);
    end
  end

  assign idle_out = (state == IDLE) && both_empty && !rd_q;

`ifdef DEST_CHECK_EN
  // Sticky flag: a presented word whose destination bit disagrees with its source FIFO.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  error_out <= 1'b0;
    else if (init) error_out <= 1'b0;
    else if (rd_q && (data_out[DEST_BIT] != src_q)) error_out <= 1'b1;
  end
`else
  assign error_out = 1'b0;
`endif

endmodule
